pipe_stage_reg: RTL and testbench

- Parametrised, handshaked successor to the fixed D->E stage register; one instance sits between any two pipeline stages (F/D, D/E, E/M, M/W).
- Carries an opaque payload plus PC, branch-delay flag and exception code under valid/ready flow control.
- Supports exception flush with vector injection, hazard-bubble insertion that preserves PC/bd for EPC, an optional skid slot, and saturating bubble and flush event counters.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/pipe_stage_reg_sat_counter.sv | 19 +
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants used by every stage register instance.
// Payload structs fix PAYLOAD_W per stage boundary via $bits().
package pipe_pkg;

  localparam int PC_W_DEFAULT  = 32;
  localparam int EXC_W_DEFAULT = 5;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_4180;
  localparam logic [4:0]  EXC_NONE        = 5'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
  } stage_meta_t;

  // Decode -> execute bundle, padded to a round 128 bits for the default instance.
  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  alu_op;
    logic [3:0]  mem_op;
    logic        reg_we;
    logic        mem_to_reg;
    logic [14:0] rsvd;
  } de_payload_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [3:0]  mem_op;
    logic        reg_we;
    logic        mem_to_reg;
  } em_payload_t;

  localparam int DE_PAYLOAD_W = $bits(de_payload_t);
  localparam int EM_PAYLOAD_W = $bits(em_payload_t);

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush/vector injection, bubble
// insertion that keeps PC/bd for EPC, an optional skid slot and event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              PAYLOAD_W = DE_PAYLOAD_W,
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter int              EXC_W     = EXC_W_DEFAULT,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEFAULT),
  parameter bit              SKID      = 1'b1,
  parameter int              CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 in_bd,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 req,
  input  logic                 stall,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic                 out_bd,
  output logic [EXC_W-1:0]     out_exc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic                 slot_free;
  logic                 skid_valid;
  logic [PC_W-1:0]      skid_pc;
  logic                 skid_bd;
  logic [EXC_W-1:0]     skid_exc;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic                 bubble_inc;
  logic                 flush_inc;

  assign slot_free  = !out_valid || out_ready;
  assign flush_inc  = req;
  assign bubble_inc = !req && stall && slot_free;

  // Output slot: flush beats stall, stall beats transfer; a drained skid wins over the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_bd      <= 1'b0;
      out_exc     <= '0;
      out_payload <= '0;
    end else if (req) begin
      out_valid   <= 1'b0;
      out_pc      <= EXC_VEC;
      out_bd      <= 1'b0;
      out_exc     <= EXC_W'(EXC_NONE);
      out_payload <= '0;
    end else if (stall) begin
      if (slot_free) begin
        out_valid   <= 1'b0;
        out_pc      <= in_pc;
        out_bd      <= in_bd;
        out_exc     <= EXC_W'(EXC_NONE);
        out_payload <= '0;
      end
    end else if (slot_free) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_pc      <= skid_pc;
        out_bd      <= skid_bd;
        out_exc     <= skid_exc;
        out_payload <= skid_payload;
      end else if (in_valid) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_bd      <= in_bd;
        out_exc     <= in_exc;
        out_payload <= in_payload;
      end else begin
        out_valid   <= 1'b0;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      logic accept;

      // Ready depends only on local state plus req/stall, never on out_ready.
      assign in_ready = !skid_valid && !stall && !req;
      assign accept   = in_valid && in_ready;

      always_ff @(posedge clk) begin
        if (rst || req) begin
          skid_valid   <= 1'b0;
          skid_pc      <= '0;
          skid_bd      <= 1'b0;
          skid_exc     <= '0;
          skid_payload <= '0;
        end else if (!stall) begin
          if (slot_free && skid_valid) begin
            skid_valid <= accept;
            if (accept) begin
              skid_pc      <= in_pc;
              skid_bd      <= in_bd;
              skid_exc     <= in_exc;
              skid_payload <= in_payload;
            end
          end else if (!slot_free && accept) begin
            skid_valid   <= 1'b1;
            skid_pc      <= in_pc;
            skid_bd      <= in_bd;
            skid_exc     <= in_exc;
            skid_payload <= in_payload;
          end
        end
      end
    end else begin : g_no_skid
      assign in_ready     = !rst && slot_free && !stall && !req;
      assign skid_valid   = 1'b0;
      assign skid_pc      = '0;
      assign skid_bd      = 1'b0;
      assign skid_exc     = '0;
      assign skid_payload = '0;
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a skid-less instance share
// stimulus; each is compared every cycle against a FIFO-style reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int PW = DE_PAYLOAD_W;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_bd, req, stall, out_ready;
  logic [31:0]   in_pc;
  logic [4:0]    in_exc;
  logic [PW-1:0] in_payload;

  logic          in_ready [2];
  logic          out_valid[2];
  logic          out_bd   [2];
  logic [31:0]   out_pc   [2];
  logic [4:0]    out_exc  [2];
  logic [PW-1:0] out_payload[2];
  logic [3:0]    bub1, fl1;
  logic [15:0]   bub0, fl0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc), .in_payload(in_payload),
    .req(req), .stall(stall), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_pc(out_pc[1]), .out_bd(out_bd[1]), .out_exc(out_exc[1]),
    .out_payload(out_payload[1]), .bubble_cnt(bub1), .flush_cnt(fl1)
  );

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) dut_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc), .in_payload(in_payload),
    .req(req), .stall(stall), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_pc(out_pc[0]), .out_bd(out_bd[0]), .out_exc(out_exc[0]),
    .out_payload(out_payload[0]), .bubble_cnt(bub0), .flush_cnt(fl0)
  );

  // Reference: the stage is a FIFO (output slot + pending beats) bounded by its capacity.
  typedef struct packed {
    logic          v;
    logic [31:0]   pc;
    logic          bd;
    logic [4:0]    exc;
    logic [PW-1:0] pl;
  } beat_t;

  beat_t       mslot[2];
  beat_t       pend [2][2];
  int          pcnt [2];
  int unsigned mbub [2];
  int unsigned mfl  [2];
  int unsigned cmax [2] = '{65535, 15};
  bit          started = 1'b0;

  function automatic bit model_ready(int k);
    if (k == 1) return (pcnt[1] == 0) && !req && !stall;
    return !rst && (!mslot[0].v || out_ready) && !req && !stall;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin : model_step
      bit free, acc;
      free = !mslot[k].v || out_ready;
      acc  = in_valid && model_ready(k);
      if (rst) begin
        mslot[k] = '0; pcnt[k] = 0; mbub[k] = 0; mfl[k] = 0;
      end else if (req) begin
        mslot[k] = '{1'b0, 32'h0000_4180, 1'b0, 5'd0, '0};
        pcnt[k]  = 0;
        if (mfl[k] < cmax[k]) mfl[k]++;
      end else if (stall) begin
        if (free) begin
          mslot[k] = '{1'b0, in_pc, in_bd, 5'd0, '0};
          if (mbub[k] < cmax[k]) mbub[k]++;
        end
      end else begin
        if (acc) begin
          pend[k][pcnt[k]] = '{1'b1, in_pc, in_bd, in_exc, in_payload};
          pcnt[k]++;
        end
        if (free) begin
          if (pcnt[k] > 0) begin
            mslot[k]   = pend[k][0];
            pend[k][0] = pend[k][1];
            pcnt[k]--;
          end else begin
            mslot[k].v = 1'b0;
          end
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("slot%0d", k),
                    {out_valid[k], out_pc[k], out_bd[k], out_exc[k], out_payload[k]}, mslot[k]);
        checkOutput($sformatf("in_ready%0d", k), in_ready[k], model_ready(k));
      end
      checkOutput("bubble_cnt1", bub1, mbub[1]);
      checkOutput("flush_cnt1",  fl1,  mfl[1]);
      checkOutput("bubble_cnt0", bub0, mbub[0]);
      checkOutput("flush_cnt0",  fl0,  mfl[0]);
    end
  end

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] pc, input bit bd,
                               input bit st, input bit rq, input bit ordy);
    rst        = r;
    in_valid   = v;
    in_pc      = pc;
    in_bd      = bd;
    stall      = st;
    req        = rq;
    out_ready  = ordy;
    in_exc     = 5'($urandom_range(0, 31));
    in_payload = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_bd = 1'b0; in_exc = '0;
    in_payload = '0; req = 1'b0; stall = 1'b0; out_ready = 1'b1;

    applyStimulus(1, 0, 32'h0, 0, 0, 0, 1);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 1);
    checkOutput("rst_out_valid", out_valid[1], 1'b0);
    checkOutput("rst_out_pc", out_pc[1], 32'h0);
    checkOutput("rst_in_ready_skid", in_ready[1], 1'b1);
    checkOutput("rst_in_ready_noskid", in_ready[0], 1'b0);
    checkOutput("rst_bubble_cnt", bub1, 4'd0);

    // Streaming at full rate
    applyStimulus(0, 1, 32'h3000, 0, 0, 0, 1);
    checkOutput("stream_pc0", out_pc[1], 32'h3000);
    checkOutput("stream_v0", out_valid[1], 1'b1);
    applyStimulus(0, 1, 32'h3004, 0, 0, 0, 1);
    checkOutput("stream_pc1", out_pc[1], 32'h3004);
    applyStimulus(0, 1, 32'h3008, 0, 0, 0, 1);
    checkOutput("stream_pc2", out_pc[1], 32'h3008);
    checkOutput("stream_bub", bub1, 4'd0);

    // Backpressure fills the skid, then drains in order
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h3000, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h3004, 0, 0, 0, 0);
    checkOutput("bp_in_ready", in_ready[1], 1'b0);
    checkOutput("bp_hold_pc", out_pc[1], 32'h3000);
    applyStimulus(0, 1, 32'h3008, 0, 0, 0, 0);
    checkOutput("bp_hold_pc2", out_pc[1], 32'h3000);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1);
    checkOutput("bp_drain_pc", out_pc[1], 32'h3004);
    checkOutput("bp_drain_v", out_valid[1], 1'b1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1);
    checkOutput("bp_empty_v", out_valid[1], 1'b0);

    // Stall bubble keeps PC/bd
    applyStimulus(0, 1, 32'h3010, 1, 1, 0, 1);
    checkOutput("bubble_v", out_valid[1], 1'b0);
    checkOutput("bubble_pc", out_pc[1], 32'h3010);
    checkOutput("bubble_bd", out_bd[1], 1'b1);
    checkOutput("bubble_payload", out_payload[1], '0);
    checkOutput("bubble_cnt", bub1, 4'd1);

    // Flush with a full skid and a concurrent stall
    applyStimulus(0, 1, 32'h3020, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h3024, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h3028, 0, 1, 1, 0);
    checkOutput("flush_pc", out_pc[1], 32'h0000_4180);
    checkOutput("flush_v", out_valid[1], 1'b0);
    checkOutput("flush_bd", out_bd[1], 1'b0);
    checkOutput("flush_cnt", fl1, 4'd1);
    checkOutput("flush_bub_kept", bub1, 4'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1);
    checkOutput("flush_skid_empty_v", out_valid[1], 1'b0);
    checkOutput("flush_skid_empty_rdy", in_ready[1], 1'b1);

    // Saturation of the 4-bit bubble counter
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 32'h3040 + 32'(i * 4), 0, 1, 0, 1);
    checkOutput("sat_bub", bub1, 4'd15);
    checkOutput("sat_flush", fl1, 4'd1);

    // Reset with slot and skid occupied
    applyStimulus(0, 1, 32'h3030, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h3034, 0, 0, 0, 0);
    checkOutput("mid_v_before", out_valid[1], 1'b1);
    applyStimulus(1, 1, 32'h3038, 0, 0, 0, 0);
    checkOutput("mid_rst_v", out_valid[1], 1'b0);
    checkOutput("mid_rst_pc", out_pc[1], 32'h0);
    checkOutput("mid_rst_bub", bub1, 4'd0);
    checkOutput("mid_rst_flush", fl1, 4'd0);
    checkOutput("mid_rst_rdy_skid", in_ready[1], 1'b1);
    checkOutput("mid_rst_rdy_noskid", in_ready[0], 1'b0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 9) < 7,
                    32'h3000 + 32'($urandom_range(0, 255) * 4),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) < 2,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 9) < 7);
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
